// File: rtl/ula_ctrl.sv
// -----------------------------------------------------------------------------
// ula_ctrl
//   Multi-cycle sequencer for one register-to-register ALU instruction at a
//   time. It reads two source registers from an 8-entry register file, hands
//   the operands and opcode to the ULA, then writes the ULA result back to the
//   destination register. Each instruction takes the sequence
//   IDLE -> READ -> EXEC -> WRITE -> IDLE, so throughput is one instruction
//   every four cycles.
//
// Optional feature:
//   ULA_CTRL_IMM_EN - adds instr_use_imm / instr_imm. When use_imm is set,
//                     operand B comes from the immediate instead of rd2 and
//                     ra2 is driven 0.
//
// Ports:
//   clk, reset            clock (rising edge), synchronous active-high reset
//   instr_valid/ready     instruction handshake (ready only in IDLE)
//   instr_op/rd/rs1/rs2   opcode, destination and source register indices
//   ra1, ra2 / rd1, rd2   register file read addresses / combinational data
//   wa3, wd3, we3         register file write port
//   alu_a, alu_b, alu_op  ULA operands and opcode (opcode not decoded here)
//   alu_y                 combinational ULA result
//   result                last written-back value
//   done                  one-cycle pulse in the write-back cycle
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module ula_ctrl #(
  parameter int DataWidth = 8,
  parameter int AddrWidth = 3,
  parameter int OpWidth   = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 instr_valid,
  output logic                 instr_ready,
  input  logic [OpWidth-1:0]   instr_op,
  input  logic [AddrWidth-1:0] instr_rd,
  input  logic [AddrWidth-1:0] instr_rs1,
  input  logic [AddrWidth-1:0] instr_rs2,
`ifdef ULA_CTRL_IMM_EN
  input  logic                 instr_use_imm,
  input  logic [DataWidth-1:0] instr_imm,
`endif
  output logic [AddrWidth-1:0] ra1,
  output logic [AddrWidth-1:0] ra2,
  input  logic [DataWidth-1:0] rd1,
  input  logic [DataWidth-1:0] rd2,
  output logic [AddrWidth-1:0] wa3,
  output logic [DataWidth-1:0] wd3,
  output logic                 we3,
  output logic [DataWidth-1:0] alu_a,
  output logic [DataWidth-1:0] alu_b,
  output logic [OpWidth-1:0]   alu_op,
  input  logic [DataWidth-1:0] alu_y,
  output logic [DataWidth-1:0] result,
  output logic                 done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    EXEC  = 2'd2,
    WRITE = 2'd3
  } state_e;

  state_e state_q, state_d;

  // Instruction fields latched at acceptance.
  logic [OpWidth-1:0]   op_q;
  logic [AddrWidth-1:0] rd_q;
`ifdef ULA_CTRL_IMM_EN
  logic                 use_imm_q;
  logic [DataWidth-1:0] imm_q;
`endif

  // Registered outputs.
  logic [AddrWidth-1:0] ra1_q, ra2_q, wa3_q;
  logic [DataWidth-1:0] wd3_q, alu_a_q, alu_b_q, result_q;
  logic [OpWidth-1:0]   alu_op_q;
  logic                 we3_q, done_q;

  // Operand B source, resolved at acceptance time for the read address and
  // in READ for the captured value.
  logic [AddrWidth-1:0] ra2_sel;
  logic [DataWidth-1:0] b_sel;

`ifdef ULA_CTRL_IMM_EN
  assign ra2_sel = instr_use_imm ? '0 : instr_rs2;
  assign b_sel   = use_imm_q ? imm_q : rd2;
`else
  assign ra2_sel = instr_rs2;
  assign b_sel   = rd2;
`endif

  // Ready is the one combinational output: it must already be low in the
  // cycles where reset is held, before any edge has cleared the state.
  assign instr_ready = (state_q == IDLE) && !reset;

  // NOTE: every variable assigned in always_comb gets a default first, so no
  // path through the block can leave it unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (instr_valid) state_d = READ;
      READ:    state_d = EXEC;
      EXEC:    state_d = WRITE;
      WRITE:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      op_q      <= '0;
      rd_q      <= '0;
`ifdef ULA_CTRL_IMM_EN
      use_imm_q <= 1'b0;
      imm_q     <= '0;
`endif
      ra1_q     <= '0;
      ra2_q     <= '0;
      wa3_q     <= '0;
      wd3_q     <= '0;
      alu_a_q   <= '0;
      alu_b_q   <= '0;
      alu_op_q  <= '0;
      result_q  <= '0;
      we3_q     <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      // Write strobes are single-cycle: only the EXEC branch raises them.
      we3_q   <= 1'b0;
      done_q  <= 1'b0;

      unique case (state_q)
        IDLE: begin
          // instr_ready is 1 whenever reset is low in IDLE.
          if (instr_valid) begin
            op_q  <= instr_op;
            rd_q  <= instr_rd;
            // Read addresses are loaded here so they are valid throughout READ.
            ra1_q <= instr_rs1;
            ra2_q <= ra2_sel;
`ifdef ULA_CTRL_IMM_EN
            use_imm_q <= instr_use_imm;
            imm_q     <= instr_imm;
`endif
          end
        end
        READ: begin
          // Operand registers double as the ULA operand outputs in EXEC.
          alu_a_q  <= rd1;
          alu_b_q  <= b_sel;
          alu_op_q <= op_q;
        end
        EXEC: begin
          result_q <= alu_y;
          wd3_q    <= alu_y;
          wa3_q    <= rd_q;
          // Register 0 is hardwired; the cycle still completes with done.
          we3_q    <= (rd_q != '0);
          done_q   <= 1'b1;
        end
        WRITE: begin
          // Outputs hold; the register file commits at the end of this cycle.
        end
        default: begin
        end
      endcase
    end
  end

  assign ra1    = ra1_q;
  assign ra2    = ra2_q;
  assign wa3    = wa3_q;
  assign wd3    = wd3_q;
  assign we3    = we3_q;
  assign alu_a  = alu_a_q;
  assign alu_b  = alu_b_q;
  assign alu_op = alu_op_q;
  assign result = result_q;
  assign done   = done_q;

endmodule

// File: doc/ula_ctrl.md
# ula_ctrl

Multi-cycle sequencer that executes one register-to-register ALU instruction at a time. It sits between an instruction source and the 8×8-bit register file / ULA pair. It reads two source registers, presents operands and opcode to the ULA, and writes the ULA result back to a destination register. It accepts instructions through a valid/ready handshake and reports completion with a one-cycle `done` pulse.

## Interface
Parameters:
- `DataWidth`, 8, operand/result width.
- `AddrWidth`, 3, register index width (8 registers; register 0 reads as 0).
- `OpWidth`, 3, ULA opcode width (passed through, not decoded).

Ports:
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `instr_valid`  in  1  instruction present.
- `instr_ready`  out  1  controller can accept an instruction.
- `instr_op`  in  OpWidth  ULA opcode.
- `instr_rd`  in  AddrWidth  destination register.
- `instr_rs1`  in  AddrWidth  source A register.
- `instr_rs2`  in  AddrWidth  source B register.
- `ra1`, `ra2`  out  AddrWidth  register file read addresses.
- `rd1`, `rd2`  in  DataWidth  register file read data (combinational).
- `wa3`  out  AddrWidth  write address.
- `wd3`  out  DataWidth  write data.
- `we3`  out  1  write enable.
- `alu_a`, `alu_b`  out  DataWidth  ULA operands.
- `alu_op`  out  OpWidth  ULA opcode.
- `alu_y`  in  DataWidth  ULA result (combinational).
- `result`  out  DataWidth  last written-back value.
- `done`  out  1  one-cycle pulse in the write-back cycle.

## Operation
- FSM states: IDLE → READ → EXEC → WRITE → IDLE. The controller handles no other states and never pipelines instructions.
- IDLE:
  - `instr_ready`=1.
  - On `instr_valid && instr_ready`, latch op/rd/rs1/rs2 and go to READ.
  - `instr_ready` is 0 in every other state; `instr_valid` is ignored there.
- READ:
  - `ra1`=rs1, `ra2`=rs2.
  - Capture `rd1`/`rd2` into operand registers A/B at the end of the cycle.
- EXEC:
  - `alu_a`=A, `alu_b`=B, `alu_op`=op.
  - Capture `alu_y` into the result register at the end of the cycle.
- WRITE:
  - `wa3`=rd, `wd3`=result, `done`=1.
  - `we3`=1 only when rd≠0. For rd=0, `we3` stays 0 and `done` still pulses.
  - `result` output updates to the new value in this cycle and holds until the next WRITE.
- Outside their active states, `ra1`/`ra2`/`wa3`/`wd3`/`alu_*` hold their last values. `we3` and `done` are 0.
- rs1/rs2 equal to a register written by the previous instruction read the new value, because write-back completes before the next READ.
- Arithmetic: the controller performs none. Widths pass through unchanged.

## Timing
- Handshake accepted at edge T. READ runs in cycle T+1, EXEC in T+2, WRITE in T+3 (`we3`/`done` high). The register file commits at the end of T+3.
- `instr_ready` is high again in cycle T+4. Throughput is 1 instruction per 4 cycles. There is no back-to-back acceptance without an IDLE cycle.
- Reset values:
  - State IDLE.
  - `instr_ready`=1 from the first cycle after reset deasserts. It is 0 while `reset` is high.
  - `we3`=0, `done`=0.
  - `ra1`=`ra2`=`wa3`=0, `wd3`=0, `alu_a`=`alu_b`=0, `alu_op`=0, `result`=0.
- Reset mid-operation, in any state including WRITE:
  - At the reset edge, return to IDLE and discard the instruction.
  - No `we3` or `done` after the reset edge.
- `instr_valid` may drop without acceptance while `instr_ready`=0. No ordering is required.

## Configuration
- `ULA_CTRL_IMM_EN` defined:
  - Adds inputs `instr_use_imm` (1) and `instr_imm` (DataWidth), both latched at acceptance.
  - When `use_imm`=1, B is loaded from imm in READ instead of `rd2`, and `ra2` is driven 0.
- Undefined: ports absent, B always from `rd2`.

## Test plan
- Reset, then observe: `instr_ready`=1, `we3`=0, `done`=0, `result`=0.
  - Assert `reset` during EXEC and confirm no write follows.
- Preload r1=0x05 and r2=0x03, issue op=ADD rd=3 rs1=1 rs2=2 at T.
  - Expect `ra1`=1/`ra2`=2 at T+1, `alu_a`=0x05/`alu_b`=0x03 at T+2.
  - Expect `we3`=1, `wa3`=3, `wd3`=0x08, `done`=1 at T+3, and `instr_ready`=1 at T+4.
- Issue rd=0 with r1=0xFF, r2=0x01: `done` pulses at T+3 with `we3`=0, and r0 still reads 0.
- Issue back-to-back dependent instructions r3=r1+r2, then r4=r3+r3 (r1=2, r2=3).
  - Second is accepted at T+4 and writes r4=0x0A at T+7.
  - `instr_valid` held high in T+1..T+3 is not accepted.
- With `ULA_CTRL_IMM_EN`, issue use_imm=1, imm=0x10, rs1=1 (r1=0x04), op=ADD, rd=5.
  - `alu_b`=0x10 in EXEC, `ra2`=0, r5=0x14 after WRITE.
